// File: rtl/jacobi_host_sequencer.sv
// rtl/jacobi_host_sequencer.sv - bus initiator that runs one load/iterate/unload job on the Jacobi array
// Optional feature: define JACOBI_HOST_POLL_EN to poll the array counter instead of counting locally.
module jacobi_host_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 8,
  parameter int IDWIDTH = 8,
  parameter int NWIDTH  = 10,
  parameter int CTRL_ID = 0,
  parameter int SCAN_ID = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [NWIDTH-1:0] Nodes,
  input  logic [CWIDTH-1:0] Iter,
  output logic              Busy,
  output logic              Done,
  input  logic              LdValid,
  output logic              LdReady,
  input  logic [WIDTH-1:0]  LdData,
  output logic              UnValid,
  input  logic              UnReady,
  output logic [WIDTH-1:0]  UnData,
  output logic              BusRD,
  output logic              BusWR,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusDataOut,
  input  logic [DATA_W-1:0] BusDataIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_GAP, S_UNLOAD, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_SCAN = ADDR_W'(SCAN_ID);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(CTRL_ID);
  localparam logic [NWIDTH-1:0] N_ONE  = NWIDTH'(1);

  state_t              r_state;
  logic [NWIDTH-1:0]   r_nodes;
  logic [CWIDTH-1:0]   r_iter;
  logic [NWIDTH-1:0]   r_ld_cnt;
  logic [NWIDTH-1:0]   r_rd_cnt;
  logic [NWIDTH-1:0]   r_un_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ld_ready;
  logic                r_un_valid;
  logic [WIDTH-1:0]    r_un_data;
`ifndef JACOBI_HOST_POLL_EN
  logic [CWIDTH-1:0]   r_run_cnt;
`endif

  logic w_ld_fire;
  logic w_un_fire;
  logic w_rd_scan;
  logic w_rd_ctrl;
  logic w_unused_din;

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign LdReady = r_ld_ready;
  assign UnValid = r_un_valid;
  assign UnData  = r_un_data;

  assign w_ld_fire = (r_state == S_LOAD) && LdValid && r_ld_ready;
  assign w_un_fire = r_un_valid && UnReady;
  // A read may only be issued if its data can land in UnData at the same edge.
  assign w_rd_scan = (r_state == S_UNLOAD) && (r_rd_cnt != r_nodes) &&
                     (!r_un_valid || UnReady);
`ifdef JACOBI_HOST_POLL_EN
  assign w_rd_ctrl = (r_state == S_RUN);
`else
  assign w_rd_ctrl = 1'b0;
`endif
  assign w_unused_din = ^BusDataIn;

  // Bus strobes follow the handshakes in the same cycle so load and unload sustain one beat per cycle.
  always_comb begin
    BusRD      = 1'b0;
    BusWR      = 1'b0;
    BusAddr    = '0;
    BusDataOut = '0;
    if (w_ld_fire) begin
      BusWR      = 1'b1;
      BusAddr    = A_SCAN;
      BusDataOut = DATA_W'(LdData);
    end else if (r_state == S_ARM) begin
      BusWR      = 1'b1;
      BusAddr    = A_CTRL;
      BusDataOut = DATA_W'(r_iter);
    end else if (w_rd_ctrl) begin
      BusRD   = 1'b1;
      BusAddr = A_CTRL;
    end else if (w_rd_scan) begin
      BusRD   = 1'b1;
      BusAddr = A_SCAN;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_nodes    <= '0;
      r_iter     <= '0;
      r_ld_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_un_cnt   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_ready <= 1'b0;
      r_un_valid <= 1'b0;
      r_un_data  <= '0;
`ifndef JACOBI_HOST_POLL_EN
      r_run_cnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_nodes  <= Nodes;
            r_iter   <= Iter;
            r_busy   <= 1'b1;
            r_ld_cnt <= '0;
            r_rd_cnt <= '0;
            r_un_cnt <= '0;
            if (Nodes == '0) begin
              r_state <= S_ARM;
            end else begin
              r_state    <= S_LOAD;
              r_ld_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_ld_fire) begin
            r_ld_cnt <= r_ld_cnt + N_ONE;
            if (r_ld_cnt + N_ONE == r_nodes) begin
              r_ld_ready <= 1'b0;
              r_state    <= S_ARM;
            end
          end
        end
        S_ARM: begin
`ifndef JACOBI_HOST_POLL_EN
          r_run_cnt <= r_iter;
`endif
          r_state <= (r_iter == '0) ? S_GAP : S_RUN;
        end
        S_RUN: begin
`ifdef JACOBI_HOST_POLL_EN
          if (BusDataIn[CWIDTH-1:0] == '0) r_state <= S_GAP;
`else
          r_run_cnt <= r_run_cnt - CWIDTH'(1);
          if (r_run_cnt == CWIDTH'(1)) r_state <= S_GAP;
`endif
        end
        S_GAP: begin
          if (r_nodes == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (w_rd_scan) begin
            r_un_data  <= BusDataIn[WIDTH-1:0];
            r_un_valid <= 1'b1;
            r_rd_cnt   <= r_rd_cnt + N_ONE;
          end else if (w_un_fire) begin
            r_un_valid <= 1'b0;
          end
          if (w_un_fire) begin
            r_un_cnt <= r_un_cnt + N_ONE;
            if (r_un_cnt + N_ONE == r_nodes) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
